// File: rtl/aes_pkg.sv
// Shared AES helpers: ShiftRows offset table, column-major byte indexing and
// the legal block-width check used by the ShiftRows stages.
package aes_pkg;

  // Row shift distance for a Rijndael state of nb columns. Row 0 never moves;
  // the 256-bit block (nb = 8) shifts rows 2 and 3 one further.
  function automatic int ROW_OFF(int nb, int r);
    int off;
    off = r;
    if (nb == 8 && r >= 2) off = r + 1;
    return off;
  endfunction

  // Byte position of state element (row r, column c): column-major packing.
  function automatic int idx(int c, int r);
    return 4 * c + r;
  endfunction

  // Block widths this datapath supports.
  function automatic bit nb_legal(int nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation. Pure wiring plus a
// final mode mux, so it can be dropped into the iterative core unchanged.
module shift_rows_perm
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [32*NB-1:0] data,
  input  logic             inv,
  output logic [32*NB-1:0] perm
);

  if (!nb_legal(NB)) begin : g_bad_nb
    $error("shift_rows_perm: NB must be 4, 6 or 8");
  end

  logic [32*NB-1:0] fwd;
  logic [32*NB-1:0] bwd;

  // Every output byte picks its source column at elaboration time.
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int FSRC = (c + ROW_OFF(NB, r)) % NB;
      localparam int BSRC = (c + NB - ROW_OFF(NB, r)) % NB;
      assign fwd[8*idx(c, r) +: 8] = data[8*idx(FSRC, r) +: 8];
      assign bwd[8*idx(c, r) +: 8] = data[8*idx(BSRC, r) +: 8];
    end
  end

  assign perm = inv ? bwd : fwd;

endmodule

// File: rtl/shift_rows_pipe.sv
// Pipelined ShiftRows stage with per-transaction direction, sideband tag and a
// valid/ready skid-free register chain of STAGES entries plus a flush input.
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB     = 4,
  parameter int STAGES = 1,
  parameter int TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_inv,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic [32*NB-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_inv,
  output logic [TAG_W-1:0]   out_tag,
  output logic [32*NB-1:0]   out_data
);

  localparam int W = 32 * NB;

  if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
    $error("shift_rows_pipe: STAGES must be 1..3");
  end

  typedef struct packed {
    logic             inv;
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     data;
  } stage_t;

  logic [W-1:0]      shifted;
  stage_t            head;
  stage_t            stg [STAGES];
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] ld;

  shift_rows_perm #(.NB(NB)) u_perm (
    .data (in_data),
    .inv  (in_inv),
    .perm (shifted)
  );

  assign head = '{inv: in_inv, tag: in_tag, data: shifted};

  // Stage i may load when it, or any stage downstream of it, has room, or the
  // consumer takes the last entry. Written in closed form to avoid a chain.
  always_comb begin
    // NOTE: give every combinational output a default first so no path leaves it unassigned and infers a latch.
    ld = '0;
    for (int i = 0; i < STAGES; i++) begin
      ld[i] = out_ready;
      for (int j = i; j < STAGES; j++) begin
        if (!vld[j]) ld[i] = 1'b1;
      end
    end
  end

  assign in_ready = ld[0] && !flush;

  // Advance the register chain; flush drops every valid, data may stay stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      // NOTE: the data registers are reset as well because out_data/out_tag/out_inv must read 0 during reset.
      for (int i = 0; i < STAGES; i++) stg[i] <= '0;
    end else if (flush) begin
      vld <= '0;
    end else begin
      // NOTE: non-blocking so each stage copies its neighbour's pre-edge value, independent of statement order.
      if (ld[0]) begin
        vld[0] <= in_valid;
        if (in_valid) stg[0] <= head;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (ld[i]) begin
          vld[i] <= vld[i-1];
          if (vld[i-1]) stg[i] <= stg[i-1];
        end
      end
    end
  end

  assign out_valid = vld[STAGES-1];
  assign out_inv   = stg[STAGES-1].inv;
  assign out_tag   = stg[STAGES-1].tag;
  assign out_data  = stg[STAGES-1].data;

endmodule
